alien_grid_controller: RTL and testbench
========================================

# alien_grid_controller

Parametrised successor to the fixed six-alien controller. Marches a ROWS×COLS alien formation across the playfield and tests the player projectile against every live alien. Keeps score and declares win or loss. Sits between the projectile controller and the VGA renderer. It adds four things the fixed controller lacks:
- step rate that speeds up as aliens die;
- single-cycle hit pulse so the projectile can be deleted;
- loss line measured from the lowest occupied row;
- explicit win flag.

## Interface
- ROWS, 2, formation rows
- COLS, 3, formation columns; N = ROWS*COLS, index = row*COLS + col
- ALIEN_W, 40, alien square size (px)
- PITCH_X / PITCH_Y, 80 / 80, alien origin spacing
- LEFT_BOUND / RIGHT_BOUND / TOP_BOUND, 144 / 584 / 134
- WIN_LINE, 444, y at which aliens win
- STEP_X / DROP_Y, 4 / 35, march step and drop distance
- PROJ_W, 14, projectile width
- TICK_MIN / TICK_PER_ALIEN, 500_000 / 500_000, step period = TICK_MIN + alive_count*TICK_PER_ALIEN cycles
- SEC_CYCLES, 50_000_000, survival-point period
- HIT_POINTS, 20; SCORE_W, 8
- clk_master  in  1  system clock; all logic on posedge
- d_reset_n  in  1  synchronous, active-low reset
- projectile_x, projectile_y  in  10  projectile origin; 10'h3FF on either input = no projectile
- aliens_x, aliens_y  out  10  formation origin (alien 0 top-left)
- alive  out  N  bit i = alien i alive
- direction  out  1  1 = right, 0 = left
- hit  out  1  one-cycle pulse on a kill
- hit_index  out  $clog2(N)  index killed; valid with hit
- score  out  SCORE_W  saturating score
- game_over  out  1  sticky end of game
- win  out  1  sticky; set only when all aliens are dead

## Operation
- Reset values (d_reset_n low at an edge):
  - aliens_x=LEFT_BOUND, aliens_y=TOP_BOUND, direction=1, alive=all ones;
  - hit=0, hit_index=0, score=0, game_over=0, win=0;
  - step and second counters 0; FSM in RUN_R.
- Reset is honoured in any state and overrides every other update in that cycle.
- FSM states:
  - RUN_R: each step, if aliens_x+STEP_X ≤ RIGHT_BOUND−GW (GW=(COLS−1)*PITCH_X+ALIEN_W), then x+=STEP_X; otherwise y+=DROP_Y and go to RUN_L (direction=0), with x unchanged.
  - RUN_L: mirror of RUN_R. Move while aliens_x−STEP_X ≥ LEFT_BOUND; otherwise drop and go to RUN_R.
  - OVER: absorbing until reset. Movement, score, hits and counters all freeze.
- Step timer:
  - counts cycles; a step fires when count ≥ period−1, then count returns to 0;
  - period is recomputed every cycle from the current alive, so an immediate step occurs if period shrinks below the count.
- Collision, alien i:
  - condition: alive[i] && projectile not sentinel && px > ax_i−PROJ_W && px < ax_i+ALIEN_W && py > ay_i && py < ay_i+ALIEN_W;
  - ax_i/ay_i are origin plus col/row pitch, computed 11 bits wide to avoid wrap.
  - Multiple hits in one cycle: lowest index wins; at most one kill per cycle.
- Kill: clear alive[i], pulse hit, load hit_index, add HIT_POINTS to score.
- Score:
  - +1 every SEC_CYCLES while not over;
  - a kill and a second tick in the same cycle add both;
  - saturates at 2^SCORE_W−1.
- Loss: the lowest row r with any alive bit satisfies aliens_y + r*PITCH_Y + ALIEN_W ≥ WIN_LINE. Then game_over=1, win=0.
- Win: alive==0. Then game_over=1, win=1.

## Timing
- Collision is compared against registered coordinates; hit, alive and score update at the edge after the projectile is sampled (latency 1).
- hit is high for exactly one cycle per kill.
- Win/loss is evaluated on registered alive/aliens_y; game_over rises one cycle after the causing update.
- A step and a kill in the same cycle both take effect; the collision uses pre-step coordinates.
- Once game_over is set, no hit is generated and no further score changes occur.

## Structure
- Package alien_pkg holds:
  - PROJ_NONE = 10'h3FF;
  - DIR_LEFT/DIR_RIGHT;
  - the state enum {RUN_R, RUN_L, OVER};
  - a popcount function.
- Sub-module alien_hit_detector: a parametrised, combinational per-alien rectangle test plus lowest-index priority encoder. Outputs any_hit and index.
- Top-level holds the FSM, timers, score and the win/loss logic.

## Test plan
- Reset with defaults → aliens 144/134, alive=6'b111111, direction=1, score=0, game_over=0, win=0.
- TICK_MIN=1, TICK_PER_ALIEN=0 → x reaches 384 after 60 steps. Step 61 sets y=169 and direction=0, with x still 384.
- Projectile (150,150) at reset formation → next cycle hit=1, hit_index=0, alive=6'b111110, score=20. Projectile 3FF → no hit.
- Kill indices 3–5, then advance y → no loss at y=324; game_over (win=0) only once y+40 ≥ 444.
- Kill all six → game_over=1, win=1; score then stays frozen for 2·SEC_CYCLES.
- Assert d_reset_n low mid-march with a hit pending → all reset values on the next edge, with no hit pulse.

Source files
------------

// File: rtl/alien_grid_controller_pkg.sv
// alien_pkg: shared definitions for the alien grid controller slice.
//   PROJ_NONE        - projectile coordinate value meaning "no projectile"
//   DIR_LEFT/RIGHT   - encoding of the direction output
//   state_e          - march/game FSM states
//   popcount()       - number of set bits, used for the live-alien count
package alien_pkg;

  localparam logic [9:0] PROJ_NONE = 10'h3FF;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    RUN_R = 2'd0,
    RUN_L = 2'd1,
    OVER  = 2'd2
  } state_e;

  // Callers zero-extend their vector to 64 bits.
  function automatic int unsigned popcount(input logic [63:0] v);
    int unsigned c;
    c = 0;
    for (int k = 0; k < 64; k++) begin
      c = c + 32'(v[k]);
    end
    return c;
  endfunction

endpackage

// File: rtl/alien_grid_controller_if.sv
// alien_grid_controller_if: bundles the projectile input and the formation /
// game-state outputs of the alien grid controller.
//   master modport - the controller (receives projectile, drives state)
//   slave  modport - the projectile source / renderer side
interface alien_grid_controller_if #(
  parameter int N       = 6,
  parameter int IDX_W   = 3,
  parameter int SCORE_W = 8
);
  logic [9:0]         projectile_x;
  logic [9:0]         projectile_y;
  logic [9:0]         aliens_x;
  logic [9:0]         aliens_y;
  logic [N-1:0]       alive;
  logic               direction;
  logic               hit;
  logic [IDX_W-1:0]   hit_index;
  logic [SCORE_W-1:0] score;
  logic               game_over;
  logic               win;

  modport master (
    input  projectile_x, projectile_y,
    output aliens_x, aliens_y, alive, direction, hit, hit_index,
           score, game_over, win
  );

  modport slave (
    output projectile_x, projectile_y,
    input  aliens_x, aliens_y, alive, direction, hit, hit_index,
           score, game_over, win
  );
endinterface

// File: rtl/alien_grid_controller_hit_detector.sv
// alien_hit_detector: combinational projectile-vs-formation test.
//   origin_x/origin_y - formation origin (alien 0 top-left)
//   proj_x/proj_y     - projectile origin, PROJ_NONE on either = none
//   alive             - live mask, bit i = alien i
//   any_hit           - at least one live alien overlaps the projectile
//   index             - lowest overlapping alien index (valid with any_hit)
module alien_hit_detector
  import alien_pkg::*;
#(
  parameter int ROWS    = 2,
  parameter int COLS    = 3,
  parameter int ALIEN_W = 40,
  parameter int PITCH_X = 80,
  parameter int PITCH_Y = 80,
  parameter int PROJ_W  = 14
) (
  input  logic [9:0]                                      origin_x,
  input  logic [9:0]                                      origin_y,
  input  logic [9:0]                                      proj_x,
  input  logic [9:0]                                      proj_y,
  input  logic [ROWS*COLS-1:0]                            alive,
  output logic                                            any_hit,
  output logic [((ROWS*COLS > 1) ? $clog2(ROWS*COLS) : 1)-1:0] index
);
  localparam int N     = ROWS * COLS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  // Wide enough that origin + pitch offsets and px + PROJ_W never wrap.
  localparam int CW    = 12;

  logic          proj_valid;
  logic [N-1:0]  hit_vec;
  logic [CW-1:0] px;
  logic [CW-1:0] py;

  assign proj_valid = (proj_x != PROJ_NONE) && (proj_y != PROJ_NONE);
  assign px = CW'(proj_x);
  assign py = CW'(proj_y);

  for (genvar gi = 0; gi < N; gi++) begin : g_alien
    localparam int ROW = gi / COLS;
    localparam int COL = gi % COLS;
    logic [CW-1:0] ax;
    logic [CW-1:0] ay;
    assign ax = CW'(origin_x) + CW'(COL * PITCH_X);
    assign ay = CW'(origin_y) + CW'(ROW * PITCH_Y);
    // px > ax - PROJ_W is rearranged so nothing goes negative near x = 0.
    assign hit_vec[gi] = alive[gi] && proj_valid
                      && (px + CW'(PROJ_W) > ax) && (px < ax + CW'(ALIEN_W))
                      && (py > ay) && (py < ay + CW'(ALIEN_W));
  end

  // Descending scan so the lowest set index is the one left standing.
  always_comb begin
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (hit_vec[i]) index = IDX_W'(i);
    end
  end

  assign any_hit = |hit_vec;
endmodule

// File: rtl/alien_grid_controller.sv
// alien_grid_controller: marches a ROWS x COLS formation, kills aliens hit by
// the player projectile, keeps a saturating score and decides win/loss.
//   clk_master - system clock, all logic on posedge
//   d_reset_n  - synchronous active-low reset
//   bus        - alien_grid_controller_if.master (projectile in, state out)
module alien_grid_controller
  import alien_pkg::*;
#(
  parameter int ROWS           = 2,
  parameter int COLS           = 3,
  parameter int ALIEN_W        = 40,
  parameter int PITCH_X        = 80,
  parameter int PITCH_Y        = 80,
  parameter int LEFT_BOUND     = 144,
  parameter int RIGHT_BOUND    = 584,
  parameter int TOP_BOUND      = 134,
  parameter int WIN_LINE       = 444,
  parameter int STEP_X         = 4,
  parameter int DROP_Y         = 35,
  parameter int PROJ_W         = 14,
  parameter int TICK_MIN       = 500_000,
  parameter int TICK_PER_ALIEN = 500_000,
  parameter int SEC_CYCLES     = 50_000_000,
  parameter int HIT_POINTS     = 20,
  parameter int SCORE_W        = 8
) (
  input logic                     clk_master,
  input logic                     d_reset_n,
  alien_grid_controller_if.master bus
);
  localparam int N           = ROWS * COLS;
  localparam int IDX_W       = (N > 1) ? $clog2(N) : 1;
  localparam int GW          = (COLS - 1) * PITCH_X + ALIEN_W;
  localparam int RIGHT_LIMIT = RIGHT_BOUND - GW;
  localparam int TICK_MAX    = TICK_MIN + N * TICK_PER_ALIEN;
  localparam int TICK_W      = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam int SEC_W       = (SEC_CYCLES > 1) ? $clog2(SEC_CYCLES) : 1;
  localparam logic [31:0] SCORE_MAX = (32'd1 << SCORE_W) - 32'd1;

  localparam logic [1:0] ST_RUN_R = RUN_R;
  localparam logic [1:0] ST_RUN_L = RUN_L;
  localparam logic [1:0] ST_OVER  = OVER;

  logic [9:0]         x_reg, x_next, y_reg, y_next;
  logic [1:0]         state_reg, state_next;
  logic               dir_reg, dir_next;
  logic [N-1:0]       alive_reg, alive_next;
  logic               hit_reg, hit_next;
  logic [IDX_W-1:0]   hit_index_reg, hit_index_next;
  logic [SCORE_W-1:0] score_reg, score_next;
  logic               over_reg, over_next, win_reg, win_next;
  logic [TICK_W-1:0]  tick_cnt_reg, tick_cnt_next;
  logic [SEC_W-1:0]   sec_cnt_reg, sec_cnt_next;

  logic               det_any;
  logic [IDX_W-1:0]   det_idx;
  logic [ROWS-1:0]    row_any;
  logic [31:0]        low_row, alive_count, tick_period, score_sum;
  logic               step_fire, sec_fire, loss;

  alien_hit_detector #(
    .ROWS(ROWS), .COLS(COLS), .ALIEN_W(ALIEN_W),
    .PITCH_X(PITCH_X), .PITCH_Y(PITCH_Y), .PROJ_W(PROJ_W)
  ) u_hit_detector (
    .origin_x(x_reg),
    .origin_y(y_reg),
    .proj_x  (bus.projectile_x),
    .proj_y  (bus.projectile_y),
    .alive   (alive_reg),
    .any_hit (det_any),
    .index   (det_idx)
  );

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    assign row_any[gi] = |alive_reg[gi*COLS +: COLS];
  end

  // The bottom-most row still holding a live alien sets the loss line.
  always_comb begin
    low_row = 32'd0;
    for (int r = 0; r < ROWS; r++) begin
      if (row_any[r]) low_row = 32'(r);
    end
  end

  assign loss = (|alive_reg) &&
                ((32'(y_reg) + low_row * 32'(PITCH_Y) + 32'(ALIEN_W)) >= 32'(WIN_LINE));

  // Period follows the live count every cycle, so a shrinking period can
  // fire a step immediately when the counter is already past it.
  assign alive_count = popcount(64'(alive_reg));
  assign tick_period = 32'(TICK_MIN) + alive_count * 32'(TICK_PER_ALIEN);
  assign step_fire   = 32'(tick_cnt_reg) >= (tick_period - 32'd1);
  assign sec_fire    = 32'(sec_cnt_reg) >= (32'(SEC_CYCLES) - 32'd1);

  always_comb begin
    x_next         = x_reg;
    y_next         = y_reg;
    state_next     = state_reg;
    dir_next       = dir_reg;
    alive_next     = alive_reg;
    hit_next       = 1'b0;
    hit_index_next = hit_index_reg;
    score_next     = score_reg;
    over_next      = over_reg;
    win_next       = win_reg;
    tick_cnt_next  = tick_cnt_reg;
    sec_cnt_next   = sec_cnt_reg;
    score_sum      = 32'(score_reg);

    case (state_reg)
      ST_RUN_R, ST_RUN_L: begin
        if (alive_reg == '0) begin
          state_next = ST_OVER;
          over_next  = 1'b1;
          win_next   = 1'b1;
        end else if (loss) begin
          state_next = ST_OVER;
          over_next  = 1'b1;
          win_next   = 1'b0;
        end else begin
          if (step_fire) begin
            tick_cnt_next = '0;
            if (state_reg == ST_RUN_R) begin
              if (32'(x_reg) + 32'(STEP_X) <= 32'(RIGHT_LIMIT)) begin
                x_next = x_reg + 10'(STEP_X);
              end else begin
                y_next     = y_reg + 10'(DROP_Y);
                state_next = ST_RUN_L;
                dir_next   = DIR_LEFT;
              end
            end else begin
              if (32'(x_reg) >= 32'(LEFT_BOUND) + 32'(STEP_X)) begin
                x_next = x_reg - 10'(STEP_X);
              end else begin
                y_next     = y_reg + 10'(DROP_Y);
                state_next = ST_RUN_R;
                dir_next   = DIR_RIGHT;
              end
            end
          end else begin
            tick_cnt_next = tick_cnt_reg + 1'b1;
          end

          // Collision uses the pre-step origin held in x_reg/y_reg.
          if (det_any) begin
            alive_next[det_idx] = 1'b0;
            hit_next            = 1'b1;
            hit_index_next      = det_idx;
            score_sum           = score_sum + 32'(HIT_POINTS);
          end

          if (sec_fire) begin
            sec_cnt_next = '0;
            score_sum    = score_sum + 32'd1;
          end else begin
            sec_cnt_next = sec_cnt_reg + 1'b1;
          end

          score_next = (score_sum > SCORE_MAX) ? SCORE_W'(SCORE_MAX)
                                               : SCORE_W'(score_sum);
        end
      end
      default: ;  // OVER: everything holds until reset
    endcase
  end

  always_ff @(posedge clk_master) begin
    if (!d_reset_n) begin
      x_reg         <= 10'(LEFT_BOUND);
      y_reg         <= 10'(TOP_BOUND);
      state_reg     <= ST_RUN_R;
      dir_reg       <= DIR_RIGHT;
      alive_reg     <= '1;
      hit_reg       <= 1'b0;
      hit_index_reg <= '0;
      score_reg     <= '0;
      over_reg      <= 1'b0;
      win_reg       <= 1'b0;
      tick_cnt_reg  <= '0;
      sec_cnt_reg   <= '0;
    end else begin
      x_reg         <= x_next;
      y_reg         <= y_next;
      state_reg     <= state_next;
      dir_reg       <= dir_next;
      alive_reg     <= alive_next;
      hit_reg       <= hit_next;
      hit_index_reg <= hit_index_next;
      score_reg     <= score_next;
      over_reg      <= over_next;
      win_reg       <= win_next;
      tick_cnt_reg  <= tick_cnt_next;
      sec_cnt_reg   <= sec_cnt_next;
    end
  end

  assign bus.aliens_x  = x_reg;
  assign bus.aliens_y  = y_reg;
  assign bus.alive     = alive_reg;
  assign bus.direction = dir_reg;
  assign bus.hit       = hit_reg;
  assign bus.hit_index = hit_index_reg;
  assign bus.score     = score_reg;
  assign bus.game_over = over_reg;
  assign bus.win       = win_reg;
endmodule

// File: tb/tb_alien_grid_controller.sv
// Directed bench for alien_grid_controller.
// dut_a: step every cycle (march, loss line, reset mid-march).
// dut_b: slow, alive-dependent step rate with 100-cycle seconds
//        (hits, speed-up, win, freeze, saturation).
module tb_alien_grid_controller;

  logic clk_master = 1'b0;
  logic rst_a_n;
  logic rst_b_n;

  int tests_run    = 0;
  int tests_failed = 0;

  int kill_x [5] = '{234, 314, 154, 234, 314};
  int kill_y [5] = '{150, 150, 230, 230, 230};

  alien_grid_controller_if #(.N(6), .IDX_W(3), .SCORE_W(8)) bus_a ();
  alien_grid_controller_if #(.N(6), .IDX_W(3), .SCORE_W(8)) bus_b ();

  alien_grid_controller #(
    .TICK_MIN(1), .TICK_PER_ALIEN(0), .SEC_CYCLES(1_000_000)
  ) dut_a (
    .clk_master(clk_master),
    .d_reset_n (rst_a_n),
    .bus       (bus_a)
  );

  alien_grid_controller #(
    .TICK_MIN(1000), .TICK_PER_ALIEN(500), .SEC_CYCLES(100)
  ) dut_b (
    .clk_master(clk_master),
    .d_reset_n (rst_b_n),
    .bus       (bus_b)
  );

  always #5 clk_master = ~clk_master;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_master);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    $display("[TB] %s observed=%0d expected=%0d", tag, obs, exp);
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int guard;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    bus_a.projectile_x = 10'h3FF;
    bus_a.projectile_y = 10'h3FF;
    bus_b.projectile_x = 10'h3FF;
    bus_b.projectile_y = 10'h3FF;
    cyc(2);

    // Reset values
    check("rst_x", bus_b.aliens_x, 144);
    check("rst_y", bus_b.aliens_y, 134);
    check("rst_alive", bus_b.alive, 6'b111111);
    check("rst_dir", bus_b.direction, 1);
    check("rst_hit", bus_b.hit, 0);
    check("rst_hit_index", bus_b.hit_index, 0);
    check("rst_score", bus_b.score, 0);
    check("rst_game_over", bus_b.game_over, 0);
    check("rst_win", bus_b.win, 0);

    // Kill alien 0 on the first cycle after reset
    rst_b_n = 1'b1;
    bus_b.projectile_x = 10'd150;
    bus_b.projectile_y = 10'd150;
    cyc(1);
    check("b_hit0", bus_b.hit, 1);
    check("b_hit0_index", bus_b.hit_index, 0);
    check("b_hit0_alive", bus_b.alive, 6'b111110);
    check("b_hit0_score", bus_b.score, 20);

    bus_b.projectile_x = 10'h3FF;
    bus_b.projectile_y = 10'h3FF;
    cyc(1);
    check("b_none_hit", bus_b.hit, 0);
    check("b_none_alive", bus_b.alive, 6'b111110);
    check("b_none_score", bus_b.score, 20);

    // Same spot again: alien 0 is dead, no second kill
    bus_b.projectile_x = 10'd150;
    bus_b.projectile_y = 10'd150;
    cyc(1);
    check("b_dead_hit", bus_b.hit, 0);
    check("b_dead_alive", bus_b.alive, 6'b111110);
    bus_b.projectile_x = 10'h3FF;
    bus_b.projectile_y = 10'h3FF;

    // Five alive -> period 3500: first step at edge 3500
    cyc(3496);
    check("b_prestep_x", bus_b.aliens_x, 144);
    check("b_prestep_score", bus_b.score, 54);
    cyc(1);
    check("b_step_x", bus_b.aliens_x, 148);
    check("b_step_score", bus_b.score, 55);

    // Kill aliens 1..5 at the shifted formation
    for (int i = 1; i <= 5; i++) begin
      bus_b.projectile_x = 10'(kill_x[i-1]);
      bus_b.projectile_y = 10'(kill_y[i-1]);
      cyc(1);
      check("b_kill_hit", bus_b.hit, 1);
      check("b_kill_index", bus_b.hit_index, i);
    end
    bus_b.projectile_x = 10'h3FF;
    bus_b.projectile_y = 10'h3FF;
    check("b_all_dead_alive", bus_b.alive, 0);
    check("b_all_dead_score", bus_b.score, 155);
    check("b_all_dead_over_latency", bus_b.game_over, 0);
    cyc(1);
    check("b_win_over", bus_b.game_over, 1);
    check("b_win_flag", bus_b.win, 1);
    check("b_win_hit", bus_b.hit, 0);
    cyc(200);
    check("b_frozen_score", bus_b.score, 155);
    check("b_frozen_over", bus_b.game_over, 1);
    check("b_frozen_win", bus_b.win, 1);

    // Reset out of OVER with a hitting projectile present
    rst_b_n = 1'b0;
    bus_b.projectile_x = 10'd150;
    bus_b.projectile_y = 10'd150;
    cyc(1);
    check("b_rst_over", bus_b.game_over, 0);
    check("b_rst_win", bus_b.win, 0);
    check("b_rst_alive", bus_b.alive, 6'b111111);
    check("b_rst_hit", bus_b.hit, 0);
    check("b_rst_score", bus_b.score, 0);
    check("b_rst_x", bus_b.aliens_x, 144);

    // Survival points and saturation
    bus_b.projectile_x = 10'h3FF;
    bus_b.projectile_y = 10'h3FF;
    rst_b_n = 1'b1;
    cyc(99);
    check("b_sec_before", bus_b.score, 0);
    cyc(1);
    check("b_sec_first", bus_b.score, 1);
    cyc(25600);
    check("b_saturate", bus_b.score, 255);

    // March right to the edge, then drop and turn
    rst_a_n = 1'b1;
    cyc(60);
    check("a_edge_x", bus_a.aliens_x, 384);
    check("a_edge_y", bus_a.aliens_y, 134);
    check("a_edge_dir", bus_a.direction, 1);
    cyc(1);
    check("a_drop_x", bus_a.aliens_x, 384);
    check("a_drop_y", bus_a.aliens_y, 169);
    check("a_drop_dir", bus_a.direction, 0);
    cyc(1);
    check("a_left_x", bus_a.aliens_x, 380);

    // Reset mid-march with a hit pending on alien 0 at (380,169)
    rst_a_n = 1'b0;
    bus_a.projectile_x = 10'd386;
    bus_a.projectile_y = 10'd185;
    cyc(1);
    check("a_rst_x", bus_a.aliens_x, 144);
    check("a_rst_y", bus_a.aliens_y, 134);
    check("a_rst_dir", bus_a.direction, 1);
    check("a_rst_alive", bus_a.alive, 6'b111111);
    check("a_rst_hit", bus_a.hit, 0);
    check("a_rst_score", bus_a.score, 0);

    // Kill row 1 while the formation moves 4 px per cycle
    bus_a.projectile_x = 10'd150;
    bus_a.projectile_y = 10'd230;
    rst_a_n = 1'b1;
    cyc(1);
    check("a_kill3", bus_a.hit_index, 3);
    check("a_kill3_hit", bus_a.hit, 1);
    bus_a.projectile_x = 10'd234;
    cyc(1);
    check("a_kill4", bus_a.hit_index, 4);
    bus_a.projectile_x = 10'd318;
    cyc(1);
    check("a_kill5", bus_a.hit_index, 5);
    check("a_kill_alive", bus_a.alive, 6'b000111);
    check("a_kill_score", bus_a.score, 60);
    bus_a.projectile_x = 10'h3FF;
    bus_a.projectile_y = 10'h3FF;

    // Only row 0 remains: loss must wait for y + 40 >= 444, i.e. y = 414
    guard = 0;
    while (bus_a.game_over !== 1'b1 && guard < 2000) begin
      cyc(1);
      guard++;
    end
    check("a_loss_over", bus_a.game_over, 1);
    check("a_loss_y", bus_a.aliens_y, 414);
    check("a_loss_win", bus_a.win, 0);
    check("a_loss_alive", bus_a.alive, 6'b000111);
    check("a_loss_score", bus_a.score, 60);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
